// File: rtl/altera_tse_tx_codegroup_gen.sv
// 1000BASE-X PCS transmit code-group generator. It turns GMII transmit bytes and the
// autonegotiation xmit mode into an even/odd aligned /I/ /C/ /S/ /T/ /R/ /V/ byte stream.
module altera_tse_tx_codegroup_gen #(
   parameter int         ENABLE_CARRIER_EXT = 1,
   parameter logic [1:0] CFG_MODE_IDLE      = 2'b00,
   parameter logic [1:0] CFG_MODE_CONFIG    = 2'b01,
   parameter logic [1:0] CFG_MODE_DATA      = 2'b10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  gmii_tx_d,
   input  logic        gmii_tx_en,
   input  logic        gmii_tx_err,
   input  logic [1:0]  xmit,
   input  logic [15:0] tx_config_reg,
   input  logic        tx_runningdisp,
   output logic [7:0]  tx_frame,
   output logic        tx_kchar,
   output logic        tx_even,
   output logic        tx_active
);

   localparam logic [7:0] K28_5  = 8'hBC;
   localparam logic [7:0] D5_6   = 8'hC5;
   localparam logic [7:0] D16_2  = 8'h50;
   localparam logic [7:0] D21_5  = 8'hB5;
   localparam logic [7:0] D2_2   = 8'h42;
   localparam logic [7:0] K_SOP  = 8'hFB;
   localparam logic [7:0] K_EOP  = 8'hFD;
   localparam logic [7:0] K_CEXT = 8'hF7;
   localparam logic [7:0] K_ERR  = 8'hFE;

   typedef enum logic [3:0] {
      IDLE_K, IDLE_D, CFG_K, CFG_D, CFG_LO, CFG_HI, DATA, EPD_T, EPD_R1, EPD_R2
   } state_t;

   state_t      r_state;
   logic [7:0]  r_frame;
   logic        r_kchar;
   logic        r_even;
   logic        r_active;
   logic        r_abort;
   logic        r_cfg_c2;
   logic [15:0] r_cfg_word;
   logic        w_ext;

   // Carrier extension is honoured only for a normally ended packet.
   assign w_ext = (ENABLE_CARRIER_EXT != 0) && !gmii_tx_en && gmii_tx_err &&
                  (gmii_tx_d == 8'h0F) && !r_abort;

   // r_state names the code-group currently on tx_frame; each clock picks the next one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE_K;
         r_frame    <= K28_5;
         r_kchar    <= 1'b1;
         r_even     <= 1'b1;
         r_active   <= 1'b0;
         r_abort    <= 1'b0;
         r_cfg_c2   <= 1'b0;
         r_cfg_word <= 16'h0000;
      end else begin
         r_even   <= ~r_even;
         r_kchar  <= 1'b1;
         r_active <= 1'b0;
         case (r_state)
            IDLE_K: begin
               r_state <= IDLE_D;
               r_frame <= tx_runningdisp ? D5_6 : D16_2;
               r_kchar <= 1'b0;
            end
            IDLE_D, CFG_HI: begin
               if (xmit == CFG_MODE_IDLE) begin
                  r_state <= IDLE_K;
                  r_frame <= K28_5;
               end else if (xmit == CFG_MODE_CONFIG) begin
                  r_state    <= CFG_K;
                  r_frame    <= K28_5;
                  r_cfg_word <= tx_config_reg;
                  if (r_state == IDLE_D) begin
                     r_cfg_c2 <= 1'b0;
                  end
               end else if ((xmit == CFG_MODE_DATA) && gmii_tx_en) begin
                  // /S/ overwrites the preamble byte sampled on this cycle
                  r_state  <= DATA;
                  r_frame  <= K_SOP;
                  r_active <= 1'b1;
               end else begin
                  r_state <= IDLE_K;
                  r_frame <= K28_5;
               end
            end
            CFG_K: begin
               r_state  <= CFG_D;
               r_frame  <= r_cfg_c2 ? D2_2 : D21_5;
               r_kchar  <= 1'b0;
               r_cfg_c2 <= ~r_cfg_c2;
            end
            CFG_D: begin
               r_state <= CFG_LO;
               r_frame <= r_cfg_word[7:0];
               r_kchar <= 1'b0;
            end
            CFG_LO: begin
               r_state <= CFG_HI;
               r_frame <= r_cfg_word[15:8];
               r_kchar <= 1'b0;
            end
            DATA: begin
               r_active <= 1'b1;
               if (r_abort || !gmii_tx_en) begin
                  r_state <= EPD_T;
                  r_frame <= K_EOP;
               end else if (xmit != CFG_MODE_DATA) begin
                  r_abort <= 1'b1;
                  r_frame <= K_ERR;
               end else if (gmii_tx_err) begin
                  r_frame <= K_ERR;
               end else begin
                  r_frame <= gmii_tx_d;
                  r_kchar <= 1'b0;
               end
            end
            EPD_T: begin
               r_state <= EPD_R1;
               r_frame <= K_CEXT;
            end
            EPD_R1, EPD_R2: begin
               // An /R/ on an even position needs a second /R/ so idle starts even
               if (w_ext) begin
                  r_state <= EPD_R1;
                  r_frame <= K_CEXT;
               end else if (r_even) begin
                  r_state <= EPD_R2;
                  r_frame <= K_CEXT;
               end else begin
                  r_state <= IDLE_K;
                  r_frame <= K28_5;
                  r_abort <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE_K;
               r_frame <= K28_5;
            end
         endcase
      end
   end

   assign tx_frame  = r_frame;
   assign tx_kchar  = r_kchar;
   assign tx_even   = r_even;
   assign tx_active = r_active;

endmodule

// File: tb/tb_altera_tse_tx_codegroup_gen.sv
// Bench for the transmit code-group generator: an ordered-set level reference model
// checked every cycle, plus hand-computed sequences for the main scenarios.
module tb_altera_tse_tx_codegroup_gen;

   localparam logic [1:0] M_IDLE = 2'b00;
   localparam logic [1:0] M_CFG  = 2'b01;
   localparam logic [1:0] M_DATA = 2'b10;

   localparam logic [8:0] CG_K  = 9'h1BC;
   localparam logic [8:0] CG_S  = 9'h1FB;
   localparam logic [8:0] CG_T  = 9'h1FD;
   localparam logic [8:0] CG_R  = 9'h1F7;
   localparam logic [8:0] CG_V  = 9'h1FE;
   localparam logic [8:0] CG_C1 = 9'h0B5;
   localparam logic [8:0] CG_C2 = 9'h042;
   localparam logic [8:0] CG_I1 = 9'h0C5;
   localparam logic [8:0] CG_I2 = 9'h050;
   localparam logic [8:0] TOK_I = 9'h100;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  gmii_tx_d;
   logic        gmii_tx_en;
   logic        gmii_tx_err;
   logic [1:0]  xmit;
   logic [15:0] tx_config_reg;
   logic        tx_runningdisp;
   logic [7:0]  tx_frame;
   logic        tx_kchar;
   logic        tx_even;
   logic        tx_active;

   int n_total = 0;
   int n_pass  = 0;

   altera_tse_tx_codegroup_gen dut (
      .clk            (clk),
      .reset          (reset),
      .gmii_tx_d      (gmii_tx_d),
      .gmii_tx_en     (gmii_tx_en),
      .gmii_tx_err    (gmii_tx_err),
      .xmit           (xmit),
      .tx_config_reg  (tx_config_reg),
      .tx_runningdisp (tx_runningdisp),
      .tx_frame       (tx_frame),
      .tx_kchar       (tx_kchar),
      .tx_even        (tx_even),
      .tx_active      (tx_active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Reference model: whole ordered sets are queued when they start
   logic [8:0] q[$];
   logic [7:0] e_frame;
   logic       e_k, e_even, e_act;
   bit         m_pkt, m_abort, m_tail, m_after_t, m_cfg_prev, m_cfg_odd;

   task automatic model_reset();
      q.delete();
      q.push_back(TOK_I);
      e_frame = 8'hBC; e_k = 1'b1; e_even = 1'b1; e_act = 1'b0;
      m_pkt = 0; m_abort = 0; m_tail = 0; m_after_t = 0; m_cfg_prev = 0; m_cfg_odd = 0;
   endtask

   task automatic model_step();
      logic [8:0] o;
      bit act;
      act = 0;
      if (q.size() != 0) begin
         o = q.pop_front();
         if (o == TOK_I) o = tx_runningdisp ? CG_I1 : CG_I2;
      end else if (m_after_t) begin
         o = CG_R; m_after_t = 0; m_tail = 1;
      end else if (m_pkt) begin
         act = 1;
         if (m_abort) begin o = CG_T; m_pkt = 0; m_after_t = 1; end
         else if (xmit != M_DATA) begin o = CG_V; m_abort = 1; end
         else if (!gmii_tx_en) begin o = CG_T; m_pkt = 0; m_after_t = 1; end
         else if (gmii_tx_err) o = CG_V;
         else o = {1'b0, gmii_tx_d};
      end else if (m_tail && ((!gmii_tx_en && gmii_tx_err && gmii_tx_d == 8'h0F && !m_abort) || e_even)) begin
         o = CG_R;
      end else if (m_tail) begin
         m_tail = 0; m_abort = 0; m_cfg_prev = 0;
         o = CG_K; q.push_back(TOK_I);
      end else if (xmit == M_CFG) begin
         if (!m_cfg_prev) m_cfg_odd = 0;
         o = CG_K;
         q.push_back(m_cfg_odd ? CG_C2 : CG_C1);
         q.push_back({1'b0, tx_config_reg[7:0]});
         q.push_back({1'b0, tx_config_reg[15:8]});
         m_cfg_odd = !m_cfg_odd; m_cfg_prev = 1;
      end else if (xmit == M_DATA && gmii_tx_en) begin
         o = CG_S; act = 1; m_pkt = 1; m_cfg_prev = 0;
      end else begin
         o = CG_K; q.push_back(TOK_I); m_cfg_prev = 0;
      end
      e_frame = o[7:0]; e_k = o[8]; e_even = !e_even; e_act = act;
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) model_reset();
      else model_step();
   end

   logic [10:0] log_q[$];

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      chk("cycle", {20'd0, tx_frame, tx_kchar, tx_even, tx_active},
                   {20'd0, e_frame, e_k, e_even, e_act});
      log_q.push_back({tx_active, tx_even, tx_kchar, tx_frame});
   end

   task automatic step(input logic [1:0] xm, input logic en, input logic err, input logic [7:0] d);
      xmit = xm; gmii_tx_en = en; gmii_tx_err = err; gmii_tx_d = d;
      @(negedge clk);
      #1;
   endtask

   task automatic chk_seq(input string name, input int start, input logic [8:0] exp[$]);
      for (int i = 0; i < exp.size(); i++) begin
         if (start + i < log_q.size()) chk(name, {23'd0, log_q[start + i][8:0]}, {23'd0, exp[i]});
         else chk(name, 32'hFFFF_FFFF, {23'd0, exp[i]});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int mark;
      logic [8:0] exp_q[$];
      reset = 1'b1; xmit = M_DATA; gmii_tx_en = 1'b0; gmii_tx_err = 1'b0; gmii_tx_d = 8'h00;
      tx_config_reg = 16'h01A0; tx_runningdisp = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_frame", {24'd0, tx_frame}, 32'hBC);
      chk("rst_kchar", {31'd0, tx_kchar}, 32'd1);
      chk("rst_even", {31'd0, tx_even}, 32'd1);
      chk("rst_active", {31'd0, tx_active}, 32'd0);
      reset = 1'b0;

      mark = log_q.size();
      repeat (4) step(M_DATA, 1'b0, 1'b0, 8'h00);
      exp_q = '{CG_I2, CG_K, CG_I2, CG_K};
      chk_seq("idle_disp0", mark, exp_q);
      for (int i = 0; i < 4; i++) chk("idle_even", {31'd0, log_q[mark + i][9]}, {31'd0, 1'(i % 2)});

      tx_runningdisp = 1'b1;
      mark = log_q.size();
      repeat (4) step(M_DATA, 1'b0, 1'b0, 8'h00);
      exp_q = '{CG_I1, CG_K, CG_I1, CG_K};
      chk_seq("idle_disp1", mark, exp_q);

      mark = log_q.size();
      repeat (9) step(M_CFG, 1'b0, 1'b0, 8'h00);
      exp_q = '{CG_I1, CG_K, CG_C1, 9'h0A0, 9'h001, CG_K, CG_C2, 9'h0A0, 9'h001};
      chk_seq("config", mark, exp_q);
      step(M_CFG, 1'b0, 1'b0, 8'h00);
      tx_config_reg = 16'h5A3C;
      mark = log_q.size();
      repeat (7) step(M_CFG, 1'b0, 1'b0, 8'h00);
      exp_q = '{CG_C1, 9'h0A0, 9'h001, CG_K, CG_C2, 9'h03C, 9'h05A};
      chk_seq("config_change", mark, exp_q);

      tx_runningdisp = 1'b0;
      step(M_DATA, 1'b0, 1'b0, 8'h00);
      step(M_DATA, 1'b0, 1'b0, 8'h00);
      mark = log_q.size();
      repeat (7) step(M_DATA, 1'b1, 1'b0, 8'h55);
      step(M_DATA, 1'b1, 1'b0, 8'hD5);
      step(M_DATA, 1'b1, 1'b0, 8'h11);
      step(M_DATA, 1'b1, 1'b0, 8'h22);
      step(M_DATA, 1'b1, 1'b0, 8'h33);
      step(M_DATA, 1'b1, 1'b0, 8'h44);
      repeat (4) step(M_DATA, 1'b0, 1'b0, 8'h00);
      exp_q = '{CG_S, 9'h055, 9'h055, 9'h055, 9'h055, 9'h055, 9'h055, 9'h0D5,
                9'h011, 9'h022, 9'h033, 9'h044, CG_T, CG_R, CG_K, CG_I2};
      chk_seq("pkt_even", mark, exp_q);
      chk("pkt_active_s", {31'd0, log_q[mark][10]}, 32'd1);
      chk("pkt_active_r", {31'd0, log_q[mark + 13][10]}, 32'd0);

      step(M_DATA, 1'b0, 1'b0, 8'h00);
      mark = log_q.size();
      repeat (7) step(M_DATA, 1'b1, 1'b0, 8'h55);
      step(M_DATA, 1'b1, 1'b0, 8'hD5);
      step(M_DATA, 1'b1, 1'b0, 8'h11);
      step(M_DATA, 1'b1, 1'b0, 8'h22);
      step(M_DATA, 1'b1, 1'b0, 8'h33);
      step(M_DATA, 1'b1, 1'b0, 8'h44);
      repeat (5) step(M_DATA, 1'b0, 1'b0, 8'h00);
      exp_q = '{CG_I2, CG_S, 9'h055, 9'h055, 9'h055, 9'h055, 9'h055, 9'h0D5,
                9'h011, 9'h022, 9'h033, 9'h044, CG_T, CG_R, CG_R, CG_K, CG_I2};
      chk_seq("pkt_odd", mark, exp_q);

      mark = log_q.size();
      step(M_DATA, 1'b1, 1'b0, 8'h55);
      step(M_DATA, 1'b1, 1'b0, 8'h55);
      step(M_DATA, 1'b1, 1'b1, 8'hAA);
      step(M_DATA, 1'b1, 1'b0, 8'hBB);
      repeat (3) step(M_DATA, 1'b0, 1'b1, 8'h0F);
      repeat (3) step(M_DATA, 1'b0, 1'b0, 8'h00);
      exp_q = '{CG_S, 9'h055, CG_V, 9'h0BB, CG_T, CG_R, CG_R, CG_R, CG_K, CG_I2};
      chk_seq("err_ext", mark, exp_q);

      mark = log_q.size();
      step(M_DATA, 1'b1, 1'b0, 8'h55);
      step(M_DATA, 1'b1, 1'b0, 8'h11);
      step(M_IDLE, 1'b1, 1'b0, 8'h22);
      step(M_IDLE, 1'b1, 1'b0, 8'h33);
      repeat (4) step(M_IDLE, 1'b0, 1'b0, 8'h00);
      exp_q = '{CG_S, 9'h011, CG_V, CG_T, CG_R, CG_R, CG_K, CG_I2};
      chk_seq("mode_abort", mark, exp_q);

      step(M_DATA, 1'b1, 1'b0, 8'h55);
      step(M_DATA, 1'b1, 1'b0, 8'h66);
      gmii_tx_d = 8'h77;
      reset = 1'b1;
      #1;
      chk("arst_frame", {24'd0, tx_frame}, 32'hBC);
      chk("arst_kchar", {31'd0, tx_kchar}, 32'd1);
      chk("arst_even", {31'd0, tx_even}, 32'd1);
      chk("arst_active", {31'd0, tx_active}, 32'd0);
      @(negedge clk);
      #1;
      reset = 1'b0;
      mark = log_q.size();
      repeat (2) step(M_DATA, 1'b0, 1'b0, 8'h00);
      exp_q = '{CG_I2, CG_K};
      chk_seq("after_rst", mark, exp_q);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/altera_tse_tx_codegroup_gen.md
Name: altera_tse_tx_codegroup_gen

Overview:
- Transmit-side 1000BASE-X code-group generator, per the IEEE 802.3 clause 36 PCS transmit process.
- Converts GMII transmit bytes plus the autonegotiation xmit mode into an 8-bit code-group stream (tx_frame/tx_kchar) for the transceiver's 8b/10b encoder.
- Mirror of the receive-side alignment/sync path: it produces /I/, /C/, /S/, /T/, /R/ and /V/ ordered sets with even/odd alignment.

Parameters:
- ENABLE_CARRIER_EXT, 1, 1 = encode GMII carrier extend (en=0, err=1, d=0x0F) as /R/; 0 = treat it as idle.
- CFG_MODE_IDLE, 2'b00, xmit encoding for IDLE.
- CFG_MODE_CONFIG, 2'b01, xmit encoding for CONFIGURATION.
- CFG_MODE_DATA, 2'b10, xmit encoding for DATA.

Ports:
- clk  in  1  transmit PCS clock (125 MHz).
- reset  in  1  asynchronous, active-high reset.
- gmii_tx_d  in  8  GMII transmit data.
- gmii_tx_en  in  1  GMII transmit enable.
- gmii_tx_err  in  1  GMII transmit error.
- xmit  in  2  autonegotiation transmit mode (IDLE/CONFIG/DATA).
- tx_config_reg  in  16  autonegotiation config word for /C/ sets.
- tx_runningdisp  in  1  transceiver running disparity, 1 = positive.
- tx_frame  out  8  code-group byte.
- tx_kchar  out  1  1 = tx_frame is a K character.
- tx_even  out  1  1 = current output is on an even (ordered-set start) position.
- tx_active  out  1  1 while /S/, data, /V/ or /T/ is being sent.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset values: tx_frame=8'hBC, tx_kchar=1, tx_even=1, tx_active=0. The FSM enters IDLE_K.
- Position: tx_even toggles every cycle after reset. Every ordered set starts with tx_even=1.
- Latency: all outputs are registered. A GMII byte on cycle n appears on tx_frame at cycle n+1.
- Code values:
  - K28.5 = BC/k
  - D5.6 = C5
  - D16.2 = 50
  - D21.5 = B5
  - D2.2 = 42
  - /S/ = FB/k
  - /T/ = FD/k
  - /R/ = F7/k
  - /V/ = FE/k
- FSM states: IDLE_K, IDLE_D, CFG_K, CFG_D, CFG_LO, CFG_HI, DATA, EPD_T, EPD_R1, EPD_R2.
- IDLE_K (even): output K28.5, then go to IDLE_D.
- IDLE_D (odd): output D5.6 (/I1/) if tx_runningdisp was 1 when K28.5 was issued, otherwise D16.2 (/I2/).
- Mode and SPD decisions are made only at the end of IDLE_D / CFG_HI, using xmit and gmii_tx_en sampled on that cycle:
  - xmit=CONFIG: go to CFG_K.
  - xmit=DATA and gmii_tx_en=1: go to DATA and emit /S/ in place of the byte currently sampled (it is the first preamble byte).
  - Otherwise: go to IDLE_K.
- Preamble shrink: if en rises while the output is on an odd position, that byte is dropped. /S/ replaces the next byte (even), so the preamble shrinks by one.
- Config sequence:
  - CFG_K outputs K28.5.
  - CFG_D outputs D21.5 (/C1/) or D2.2 (/C2/). /C1/ and /C2/ alternate, starting with /C1/ after entry.
  - CFG_LO outputs tx_config_reg[7:0], CFG_HI outputs tx_config_reg[15:8]. The word is latched at CFG_K so both bytes come from one sample.
- DATA, per cycle:
  - en=1, err=0: output gmii_tx_d, kchar=0.
  - en=1, err=1: output /V/.
  - en=0: output /T/, go to EPD_T handling.
- EPD_T → EPD_R1: output /R/. If that /R/ lands on an even position, go to EPD_R2 (second /R/, odd). Otherwise go to IDLE_K. Idle therefore always starts even.
- Carrier extend (ENABLE_CARRIER_EXT=1): in EPD_R1/EPD_R2, if en=0, err=1, d=0x0F, keep emitting /R/. When extension ends, complete the alignment rule above.
- Mid-packet mode change: if xmit leaves DATA during DATA, output /V/ next, then /T/ /R/ (/R/), then enter the new mode at the next even boundary.
- In IDLE mode gmii_tx_en is ignored.
- tx_active: 1 from the /S/ cycle through the /T/ cycle inclusive.
- Reset mid-packet: outputs return to reset values immediately (asynchronous). Decoding restarts in IDLE_K on the first clock after deassertion.

Test Plan:
- Reset release, xmit=DATA, en=0: BC/k, 50 (disp=0) repeats; tx_even alternates 1,0; tx_active=0. Same with disp=1: the second byte is C5.
- xmit=CONFIG, tx_config_reg=16'h01A0: sequence BC,B5,A0,01,BC,42,A0,01 repeats. Change the register mid-set: the new value appears only from the next CFG_K.
- Packet: en rises aligned even with 55,55,…,D5, then 4 data bytes: FB/k replaces the first 55, data passes with 1-cycle latency, tx_active high, ending /T/ then /R/ with even-start idle. Repeat with odd-aligned en rise: one preamble byte dropped.
- Odd-length end: /T/ on odd position → /R/ on even, second /R/ on odd, then BC on even. /T/ on even → single /R/.
- Error and extend: err=1 during data → FE/k on exactly that cycle. After en falls, err=1, d=0F for 3 cycles → /T/ then /R/ for 3 cycles, plus an alignment /R/ if needed.
- Async reset mid-packet: outputs become BC/k, tx_even=1, tx_active=0 without a clock. xmit DATA→IDLE mid-packet → /V/, /T/, /R/(/R/), then idle.
